// File: rtl/jet_stream_pkg.sv
// Shared definitions for the jet stream collector: FSM states and the header beat layout.
package jet_stream_pkg;

  localparam logic [7:0] HDR_MAGIC     = 8'hE7;
  localparam int         HDR_MAGIC_LSB = 56;
  localparam int         HDR_EVT_LSB   = 40;
  localparam int         HDR_CNT_LSB   = 32;
  localparam int         HDR_OVF_BIT   = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HEADER,
    ST_DRAIN
  } state_e;

  function automatic logic [63:0] make_header(input logic [15:0] evt_id,
                                              input logic [7:0]  jet_count,
                                              input logic        overflow);
    logic [63:0] h;
    h                         = '0;
    h[HDR_MAGIC_LSB +: 8]     = HDR_MAGIC;
    h[HDR_EVT_LSB +: 16]      = evt_id;
    h[HDR_CNT_LSB +: 8]       = jet_count;
    h[HDR_OVF_BIT]            = overflow;
    return h;
  endfunction

endpackage

// File: rtl/jet_fifo.sv
// Synchronous FIFO with a dual-pop read side: the two oldest entries are always visible,
// and the consumer retires 0, 1 or 2 of them per cycle.
module jet_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic [1:0]                 pop_n_i,
  output logic [W-1:0]               rd_data0_o,
  output logic [W-1:0]               rd_data1_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  assign rd_data0_o = mem_q[rd_ptr_q];
  assign rd_data1_o = mem_q[ptr_add(rd_ptr_q, 2'd1)];
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

  // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_add(wr_ptr_q, 2'd1);
      rd_ptr_q <= ptr_add(rd_ptr_q, pop_n_i);
      count_q  <= count_q + CW'(push_i) - CW'(pop_n_i);
    end
  end

endmodule

// File: rtl/jet_stream_collector.sv
// Collects one event's jet words, closes the event after an idle timeout and emits
// a header beat followed by the jets packed two per 64-bit beat.
module jet_stream_collector
  import jet_stream_pkg::*;
#(
  parameter int MAX_JETS = 16,
  parameter int TIMEOUT  = 64,
  parameter int EVT_W    = 16
) (
  input  logic             s_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      din,
  input  logic             vld_in,
  output logic             rdy_out,
  output logic [63:0]      dout,
  output logic             vld_out,
  output logic             last_out,
  input  logic             rdy_in,
  output logic [EVT_W-1:0] evt_count,
  output logic [15:0]      drop_count
);

  localparam int            CW       = $clog2(MAX_JETS + 1);
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_JETS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  state_e           state_q;
  logic             start_pend_q;
  logic [EVT_W-1:0] evt_id_q;
  logic [EVT_W-1:0] evt_cnt_q;
  logic [15:0]      drop_cnt_q;
  logic [CW-1:0]    jet_cnt_q;
  logic             ovf_q;
  logic [TW-1:0]    tmo_q;
  logic             rdy_out_q;
  logic             vld_out_q;
  logic             last_out_q;
  logic [63:0]      dout_q;

  logic             accept;
  logic             out_hs;
  logic             load_beat;
  logic             two_left;
  logic             fifo_push;
  logic             fifo_flush;
  logic             fifo_empty;
  logic [1:0]       fifo_pop_n;
  logic [31:0]      fifo_rd0;
  logic [31:0]      fifo_rd1;
  logic [CW-1:0]    fifo_count;
  logic [63:0]      beat_d;
  logic             beat_last_d;

  assign accept      = rdy_out_q & vld_in;
  assign out_hs      = vld_out_q & rdy_in;
  assign fifo_push   = accept & (jet_cnt_q < CNT_MAX);
  assign fifo_flush  = (state_q == ST_IDLE) & (start | start_pend_q);

  // A payload beat is loaded on every handshake that is not the frame's last beat.
  assign load_beat   = out_hs & ~last_out_q & ~fifo_empty &
                       ((state_q == ST_HEADER) | (state_q == ST_DRAIN));
  assign two_left    = (fifo_count >= CW'(2));
  assign fifo_pop_n  = load_beat ? (two_left ? 2'd2 : 2'd1) : 2'd0;
  assign beat_d      = {fifo_rd0, two_left ? fifo_rd1 : 32'h0};
  assign beat_last_d = (fifo_count <= CW'(2));

  jet_fifo #(
    .DEPTH (MAX_JETS),
    .W     (32)
  ) u_fifo (
    .clk        (s_clk),
    .rst_n      (reset_n),
    .flush_i    (fifo_flush),
    .push_i     (fifo_push),
    .wr_data_i  (din),
    .pop_n_i    (fifo_pop_n),
    .rd_data0_o (fifo_rd0),
    .rd_data1_o (fifo_rd1),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge s_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      start_pend_q <= 1'b0;
      evt_id_q     <= '0;
      evt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      jet_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      tmo_q        <= '0;
      rdy_out_q    <= 1'b0;
      vld_out_q    <= 1'b0;
      last_out_q   <= 1'b0;
      dout_q       <= '0;
    end else begin
      // Starts that arrive while busy collapse into a single deferred start.
      if (start && (state_q != ST_IDLE)) start_pend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start || start_pend_q) begin
            state_q      <= ST_COLLECT;
            start_pend_q <= 1'b0;
            evt_id_q     <= evt_cnt_q;
            jet_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            tmo_q        <= '0;
            rdy_out_q    <= 1'b1;
          end
        end

        ST_COLLECT: begin
          if (accept) begin
            tmo_q <= '0;
            if (jet_cnt_q < CNT_MAX) begin
              jet_cnt_q <= jet_cnt_q + CW'(1);
            end else begin
              ovf_q <= 1'b1;
              if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
          end else if (tmo_q == TMO_LAST) begin
            // Close one cycle early so the registered header appears exactly TIMEOUT cycles after the last word.
            state_q    <= ST_HEADER;
            rdy_out_q  <= 1'b0;
            vld_out_q  <= 1'b1;
            dout_q     <= make_header(16'(evt_id_q), 8'(jet_cnt_q), ovf_q);
            last_out_q <= (jet_cnt_q == '0);
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        ST_HEADER, ST_DRAIN: begin
          if (out_hs) begin
            if (last_out_q) begin
              state_q    <= ST_IDLE;
              evt_cnt_q  <= evt_cnt_q + EVT_W'(1);
              vld_out_q  <= 1'b0;
              last_out_q <= 1'b0;
            end else begin
              state_q    <= ST_DRAIN;
              dout_q     <= beat_d;
              last_out_q <= beat_last_d;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdy_out    = rdy_out_q;
  assign dout       = dout_q;
  assign vld_out    = vld_out_q;
  assign last_out   = last_out_q;
  assign evt_count  = evt_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_jet_stream_collector.sv
// Directed bench for jet_stream_collector: a frame-level scoreboard checks every output
// handshake and stall, while literal expectations pin headers, payload and timing.
module tb_jet_stream_collector;

  localparam int MAX_JETS = 16;
  localparam int TIMEOUT  = 64;
  localparam int EVT_W    = 16;

  logic             s_clk   = 1'b0;
  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic [31:0]      din     = '0;
  logic             vld_in  = 1'b0;
  logic             rdy_in  = 1'b0;
  logic             rdy_out;
  logic [63:0]      dout;
  logic             vld_out;
  logic             last_out;
  logic [EVT_W-1:0] evt_count;
  logic [15:0]      drop_count;

  jet_stream_collector #(
    .MAX_JETS (MAX_JETS),
    .TIMEOUT  (TIMEOUT),
    .EVT_W    (EVT_W)
  ) dut (
    .s_clk      (s_clk),
    .reset_n    (reset_n),
    .start      (start),
    .din        (din),
    .vld_in     (vld_in),
    .rdy_out    (rdy_out),
    .dout       (dout),
    .vld_out    (vld_out),
    .last_out   (last_out),
    .rdy_in     (rdy_in),
    .evt_count  (evt_count),
    .drop_count (drop_count)
  );

  always #5 s_clk = ~s_clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    model_evt = 0;
  int    next_id   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  // Frame model: header, then jets paired high/low, odd tail padded with zero.
  task automatic push_frame(input logic [31:0] jets[$]);
    int    n;
    int    cnt;
    beat_t b;
    n      = jets.size();
    cnt    = (n > MAX_JETS) ? MAX_JETS : n;
    b.data = {8'hE7, 16'(next_id), 8'(cnt), ((n > MAX_JETS) ? 1'b1 : 1'b0), 31'b0};
    b.last = (cnt == 0);
    exp_q.push_back(b);
    for (int i = 0; i < cnt; i += 2) begin
      b.data = {jets[i], (i + 1 < cnt) ? jets[i+1] : 32'h0};
      b.last = (i + 2 >= cnt);
      exp_q.push_back(b);
    end
    next_id++;
  endtask

  task automatic send_jets(input int n, input logic [31:0] base);
    logic [31:0] jets[$];
    for (int i = 0; i < n; i++) begin
      jets.push_back(base + 32'(i));
      vld_in = 1'b1;
      din    = base + 32'(i);
      tick();
    end
    vld_in = 1'b0;
    din    = '0;
    push_frame(jets);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called one cycle after the last accepted word (or after the start pulse).
  task automatic expect_header_timing(input string name);
    repeat (TIMEOUT - 2) tick();
    check({name, "_hdr_early"}, vld_out, 1'b0);
    tick();
    check({name, "_hdr_vld"}, vld_out, 1'b1);
  endtask

  task automatic drain(input bit toggle, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      rdy_in = toggle ? ~rdy_in : 1'b1;
      tick();
      k++;
    end
    check("drain_done", exp_q.size(), 0);
    exp_q.delete();
    rdy_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_vld(input int budget);
    int k;
    k = 0;
    while (!vld_out && k < budget) begin
      tick();
      k++;
    end
    check("wait_vld", vld_out, 1'b1);
  endtask

  // Compare process: stall stability, scoreboard order and frame count every cycle.
  initial begin : compare
    logic        pv;
    logic        pr;
    logic        pl;
    logic [63:0] pd;
    beat_t       b;
    pv = 1'b0;
    pr = 1'b0;
    pl = 1'b0;
    pd = '0;
    forever begin
      @(negedge s_clk);
      if (!reset_n) begin
        exp_q.delete();
        model_evt = 0;
        next_id   = 0;
        pv        = 1'b0;
      end else begin
        check("evt_count", evt_count, 64'(model_evt));
        if (pv && !pr) begin
          check("hold_vld", vld_out, 1'b1);
          check("hold_dout", dout, pd);
          check("hold_last", last_out, pl);
        end
        if (vld_out && rdy_in) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", vld_out, 1'b0);
          end else begin
            b = exp_q.pop_front();
            check("beat_dout", dout, b.data);
            check("beat_last", last_out, b.last);
            if (b.last) model_evt++;
          end
        end
        pv = vld_out;
        pr = rdy_in;
        pd = dout;
        pl = last_out;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1);
  end

  initial begin : main
    repeat (3) @(posedge s_clk);
    #1;
    check("rst_rdy_out", rdy_out, 1'b0);
    check("rst_vld_out", vld_out, 1'b0);
    check("rst_last_out", last_out, 1'b0);
    check("rst_dout", dout, 64'h0);
    check("rst_evt_count", evt_count, 0);
    check("rst_drop_count", drop_count, 0);
    reset_n = 1'b1;
    tick();

    // 1: three jets, odd tail, start-to-ready and timeout latency.
    check("t1_rdy_idle", rdy_out, 1'b0);
    do_start();
    check("t1_rdy_collect", rdy_out, 1'b1);
    send_jets(3, 32'hA000_0001);
    expect_header_timing("t1");
    check("t1_hdr", dout, 64'hE700_0003_0000_0000);
    check("t1_hdr_last", last_out, 1'b0);
    check("t1_rdy_header", rdy_out, 1'b0);
    rdy_in = 1'b1;
    tick();
    check("t1_beat0", dout, 64'hA000_0001_A000_0002);
    check("t1_beat0_last", last_out, 1'b0);
    tick();
    check("t1_beat1", dout, 64'hA000_0003_0000_0000);
    check("t1_beat1_last", last_out, 1'b1);
    tick();
    rdy_in = 1'b0;
    check("t1_evt_count", evt_count, 1);
    check("t1_vld_end", vld_out, 1'b0);
    drain(1'b0, 10);

    // 2: empty event gives a lone header marked last.
    do_start();
    send_jets(0, 32'h0);
    expect_header_timing("t2");
    check("t2_hdr", dout, 64'hE700_0100_0000_0000);
    check("t2_hdr_last", last_out, 1'b1);
    drain(1'b0, 20);
    check("t2_evt_count", evt_count, 2);

    // 3: overflow by two jets.
    do_start();
    send_jets(MAX_JETS + 2, 32'hC000_0000);
    check("t3_drop_count", drop_count, 2);
    expect_header_timing("t3");
    check("t3_hdr", dout, 64'hE700_0210_8000_0000);
    drain(1'b0, 40);
    check("t3_evt_count", evt_count, 3);

    // 4: four jets with downstream ready toggling every cycle.
    do_start();
    send_jets(4, 32'hD000_0000);
    drain(1'b1, TIMEOUT + 40);

    // 5: two starts during DRAIN collapse into one deferred start.
    do_start();
    send_jets(4, 32'hE000_0000);
    wait_vld(TIMEOUT + 10);
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    check("t5_beat0_last", last_out, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_rdy_drain", rdy_out, 1'b0);
    rdy_in = 1'b1;
    tick();
    check("t5_beat1_last", last_out, 1'b1);
    tick();
    check("t5_idle_rdy", rdy_out, 1'b0);
    check("t5_idle_vld", vld_out, 1'b0);
    tick();
    check("t5_collect_rdy", rdy_out, 1'b1);
    rdy_in = 1'b0;
    send_jets(1, 32'hF000_0000);
    expect_header_timing("t5");
    check("t5_hdr", dout, 64'hE700_0501_0000_0000);
    drain(1'b0, 20);
    repeat (3) tick();
    check("t5_single_pending", rdy_out, 1'b0);

    // 6: reset in the middle of DRAIN, then a clean two-jet frame.
    do_start();
    send_jets(4, 32'h1234_0000);
    wait_vld(TIMEOUT + 10);
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_async_vld", vld_out, 1'b0);
    tick();
    check("t6_rst_vld", vld_out, 1'b0);
    check("t6_rst_last", last_out, 1'b0);
    check("t6_rst_rdy", rdy_out, 1'b0);
    check("t6_rst_dout", dout, 64'h0);
    check("t6_rst_evt", evt_count, 0);
    check("t6_rst_drop", drop_count, 0);
    reset_n = 1'b1;
    tick();
    do_start();
    send_jets(2, 32'h5555_0000);
    expect_header_timing("t6");
    check("t6_hdr", dout, 64'hE700_0002_0000_0000);
    check("t6_hdr_last", last_out, 1'b0);
    drain(1'b0, 20);
    check("t6_evt_count", evt_count, 1);

    repeat (4) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
